// File: rtl/uart_fifo_ctrl_if.sv
// MMIO-side and PHY-side signal bundle for the UART byte sequencer.
interface uart_fifo_ctrl_if;
  logic [7:0] uart_t_data;
  logic       uart_t_ctrl;
  logic       uart_t_state;
  logic [1:0] uart_r_ctrl;
  logic [7:0] uart_r_data;
  logic       uart_r_state;
  logic       rx_overrun;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       tx_busy;
  logic       rx_valid;
  logic [7:0] rx_byte;

  // Environment side: CPU register writes and the TX/RX PHY cores.
  modport master (
    output uart_t_data, uart_t_ctrl, uart_r_ctrl, tx_busy, rx_valid, rx_byte,
    input  uart_t_state, uart_r_data, uart_r_state, rx_overrun, tx_start, tx_byte
  );

  // Controller side.
  modport slave (
    input  uart_t_data, uart_t_ctrl, uart_r_ctrl, tx_busy, rx_valid, rx_byte,
    output uart_t_state, uart_r_data, uart_r_state, rx_overrun, tx_start, tx_byte
  );
endinterface

// File: rtl/uart_fifo_ctrl.sv
// UART byte sequencer: TX FIFO feeding a start/busy PHY handshake, RX FIFO
// buffering received bytes for polled MMIO reads, with sticky overrun flag.
module uart_fifo_ctrl #(
  parameter int unsigned DEPTH = 4
) (
  input logic             clk,
  input logic             rst_n,
  uart_fifo_ctrl_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} tx_state_t;

  logic          t_ctrl_q;
  logic          r_pop_q;

  logic [7:0]    tx_mem [DEPTH];
  logic [AW-1:0] tx_wr;
  logic [AW-1:0] tx_rd;
  logic [CW-1:0] tx_cnt;
  tx_state_t     tx_state;
  logic          tx_start_q;
  logic [7:0]    tx_byte_q;

  logic [7:0]    rx_mem [DEPTH];
  logic [AW-1:0] rx_wr;
  logic [AW-1:0] rx_rd;
  logic [CW-1:0] rx_cnt;
  logic          overrun_q;

  logic push_edge;
  logic pop_edge;
  logic tx_push;
  logic tx_pop;
  logic rx_full;
  logic rx_empty;
  logic rx_pop;
  logic rx_push;

  assign push_edge = bus.uart_t_ctrl & ~t_ctrl_q;
  assign pop_edge  = bus.uart_r_ctrl[0] & ~r_pop_q;

  assign tx_push  = push_edge && (tx_cnt != FULL_CNT);
  assign tx_pop   = (tx_state == IDLE) && (tx_cnt != '0) && !bus.tx_busy;

  assign rx_full  = (rx_cnt == FULL_CNT);
  assign rx_empty = (rx_cnt == '0);
  assign rx_pop   = pop_edge && !rx_empty;
  // A pop in the same cycle frees the slot the incoming byte needs.
  assign rx_push  = bus.rx_valid && (!rx_full || rx_pop);

  // Previous-cycle copies of the CPU strobes for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      t_ctrl_q <= 1'b0;
      r_pop_q  <= 1'b0;
    end else begin
      t_ctrl_q <= bus.uart_t_ctrl;
      r_pop_q  <= bus.uart_r_ctrl[0];
    end
  end

  // TX FIFO storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_wr  <= '0;
      tx_rd  <= '0;
      tx_cnt <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr] <= bus.uart_t_data;
        tx_wr         <= tx_wr + 1'b1;
      end
      if (tx_pop) tx_rd <= tx_rd + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + 1'b1;
        2'b01:   tx_cnt <= tx_cnt - 1'b1;
        default: tx_cnt <= tx_cnt;
      endcase
    end
  end

  // TX handshake FSM: issue a start, wait for the PHY to go busy, then idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_state   <= IDLE;
      tx_start_q <= 1'b0;
      tx_byte_q  <= '0;
    end else begin
      tx_start_q <= 1'b0;
      case (tx_state)
        IDLE: begin
          if (tx_pop) begin
            tx_start_q <= 1'b1;
            tx_byte_q  <= tx_mem[tx_rd];
            tx_state   <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: if (bus.tx_busy)  tx_state <= WAIT_DONE;
        WAIT_DONE: if (!bus.tx_busy) tx_state <= IDLE;
        default:   tx_state <= IDLE;
      endcase
    end
  end

  // RX FIFO with flush priority and sticky overrun on a dropped byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_wr     <= '0;
      rx_rd     <= '0;
      rx_cnt    <= '0;
      overrun_q <= 1'b0;
    end else if (bus.uart_r_ctrl[1]) begin
      rx_wr     <= '0;
      rx_rd     <= '0;
      rx_cnt    <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr] <= bus.rx_byte;
        rx_wr         <= rx_wr + 1'b1;
      end
      if (rx_pop) rx_rd <= rx_rd + 1'b1;
      if (bus.rx_valid && !rx_push) overrun_q <= 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 1'b1;
        2'b01:   rx_cnt <= rx_cnt - 1'b1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end

  assign bus.uart_t_state = (tx_cnt != FULL_CNT);
  assign bus.uart_r_state = !rx_empty;
  assign bus.uart_r_data  = rx_empty ? '0 : rx_mem[rx_rd];
  assign bus.rx_overrun   = overrun_q;
  assign bus.tx_start     = tx_start_q;
  assign bus.tx_byte      = tx_byte_q;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: TX scoreboard with a PHY busy model, RX vector
// table, and hand-written corner sequences.
module tb_uart_fifo_ctrl;

  logic clk;
  logic rst_n;
  uart_fifo_ctrl_if bus ();

  uart_fifo_ctrl #(.DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_starts = 0;
  int last_start = -100;
  logic [7:0] tx_exp [$];
  logic [7:0] rx_q [$];
  logic busy_force = 1'b0;
  logic phy_en = 1'b1;
  int phy_cnt = 0;
  logic phy_on = 1'b0;

  typedef struct {
    logic       rx_valid;
    logic [7:0] rx_byte;
    logic [1:0] r_ctrl;
    logic       e_state;
    logic [7:0] e_data;
    logic       e_ovr;
  } vec_t;

  vec_t vt [21];

  function automatic vec_t mk(logic v, logic [7:0] b, logic [1:0] c,
                              logic es, logic [7:0] ed, logic eo);
    return '{v, b, c, es, ed, eo};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // TX monitor: compare each start against the scoreboard and check spacing.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.tx_start === 1'b1) begin
        chk("tx_expected", tx_exp.size() > 0, 1);
        if (tx_exp.size() > 0) chk("tx_byte", bus.tx_byte, tx_exp.pop_front());
        if (n_starts > 0) chk("tx_gap_ge3", (cyc - last_start) >= 3, 1);
        last_start = cyc;
        n_starts++;
      end
    end
  end

  // PHY model: busy from one cycle after a start, held for 10 cycles.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (phy_cnt > 0) begin
        phy_on = 1'b1;
        phy_cnt--;
      end else begin
        phy_on = 1'b0;
      end
      if (bus.tx_start === 1'b1 && phy_en) phy_cnt = 10;
      bus.tx_busy = busy_force | phy_on;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int s0;
    int e;
    int n;
    logic [7:0] ex;

    rst_n = 1'b0;
    bus.uart_t_data = '0;
    bus.uart_t_ctrl = 1'b0;
    bus.uart_r_ctrl = '0;
    bus.rx_valid    = 1'b0;
    bus.rx_byte     = '0;

    // Reset with inputs toggling
    for (int i = 0; i < 2; i++) begin
      bus.uart_t_data = 8'($urandom);
      bus.uart_t_ctrl = 1'($urandom);
      bus.uart_r_ctrl = 2'($urandom);
      bus.rx_valid    = 1'($urandom);
      bus.rx_byte     = 8'($urandom);
      busy_force      = 1'($urandom);
      step();
    end
    chk("rst_t_state", bus.uart_t_state, 1);
    chk("rst_r_state", bus.uart_r_state, 0);
    chk("rst_r_data", bus.uart_r_data, 0);
    chk("rst_tx_start", bus.tx_start, 0);
    chk("rst_tx_byte", bus.tx_byte, 0);
    chk("rst_overrun", bus.rx_overrun, 0);
    bus.uart_t_ctrl = 1'b0;
    bus.uart_r_ctrl = '0;
    bus.rx_valid    = 1'b0;
    busy_force      = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();

    // Single TX
    s0 = n_starts;
    bus.uart_t_data = 8'h41;
    bus.uart_t_ctrl = 1'b1;
    tx_exp.push_back(8'h41);
    e = cyc;
    step();
    bus.uart_t_ctrl = 1'b0;
    for (int i = 0; i < 30 && n_starts == s0; i++) step();
    chk("tx1_latency", last_start - e, 2);
    repeat (20) step();
    chk("tx1_count", n_starts - s0, 1);

    // TX burst with busy held
    busy_force = 1'b1;
    step();
    step();
    s0 = n_starts;
    for (int k = 0; k < 5; k++) begin
      bus.uart_t_data = 8'h10 + 8'(k);
      bus.uart_t_ctrl = 1'b1;
      if (k < 4) tx_exp.push_back(8'h10 + 8'(k));
      step();
      chk("burst_t_state", bus.uart_t_state, (k < 3) ? 1 : 0);
      bus.uart_t_ctrl = 1'b0;
      step();
    end
    repeat (5) step();
    chk("burst_held_no_start", n_starts - s0, 0);
    busy_force = 1'b0;
    for (int i = 0; i < 100 && (n_starts - s0) < 4; i++) step();
    chk("burst_starts", n_starts - s0, 4);
    chk("burst_queue_empty", tx_exp.size(), 0);
    repeat (25) step();
    chk("burst_no_fifth", n_starts - s0, 4);
    chk("burst_t_state_drained", bus.uart_t_state, 1);

    // RX table: overrun, pops to empty, empty pop, flush colliding with rx_valid
    vt[0]  = mk(1, 8'hA0, 2'b00, 1, 8'hA0, 0);
    vt[1]  = mk(1, 8'hA1, 2'b00, 1, 8'hA0, 0);
    vt[2]  = mk(1, 8'hA2, 2'b00, 1, 8'hA0, 0);
    vt[3]  = mk(1, 8'hA3, 2'b00, 1, 8'hA0, 0);
    vt[4]  = mk(1, 8'hA4, 2'b00, 1, 8'hA0, 1);
    vt[5]  = mk(0, 8'h00, 2'b01, 1, 8'hA1, 1);
    vt[6]  = mk(0, 8'h00, 2'b00, 1, 8'hA1, 1);
    vt[7]  = mk(0, 8'h00, 2'b01, 1, 8'hA2, 1);
    vt[8]  = mk(0, 8'h00, 2'b00, 1, 8'hA2, 1);
    vt[9]  = mk(0, 8'h00, 2'b01, 1, 8'hA3, 1);
    vt[10] = mk(0, 8'h00, 2'b00, 1, 8'hA3, 1);
    vt[11] = mk(0, 8'h00, 2'b01, 0, 8'h00, 1);
    vt[12] = mk(0, 8'h00, 2'b00, 0, 8'h00, 1);
    vt[13] = mk(0, 8'h00, 2'b01, 0, 8'h00, 1);
    vt[14] = mk(0, 8'h00, 2'b00, 0, 8'h00, 1);
    vt[15] = mk(1, 8'hD0, 2'b00, 1, 8'hD0, 1);
    vt[16] = mk(1, 8'hD1, 2'b00, 1, 8'hD0, 1);
    vt[17] = mk(1, 8'hCC, 2'b10, 0, 8'h00, 0);
    vt[18] = mk(0, 8'h00, 2'b00, 0, 8'h00, 0);
    vt[19] = mk(0, 8'h00, 2'b01, 0, 8'h00, 0);
    vt[20] = mk(0, 8'h00, 2'b00, 0, 8'h00, 0);
    for (int i = 0; i < 21; i++) begin
      bus.rx_valid    = vt[i].rx_valid;
      bus.rx_byte     = vt[i].rx_byte;
      bus.uart_r_ctrl = vt[i].r_ctrl;
      step();
      chk($sformatf("vec%0d_r_state", i), bus.uart_r_state, vt[i].e_state);
      chk($sformatf("vec%0d_r_data", i), bus.uart_r_data, vt[i].e_data);
      chk($sformatf("vec%0d_overrun", i), bus.rx_overrun, vt[i].e_ovr);
      chk($sformatf("vec%0d_t_state", i), bus.uart_t_state, 1);
    end
    bus.rx_valid    = 1'b0;
    bus.uart_r_ctrl = '0;
    step();

    // Full RX with simultaneous pop edge and incoming byte
    for (int k = 0; k < 4; k++) begin
      bus.rx_valid = 1'b1;
      bus.rx_byte  = 8'hB1 + 8'(k);
      rx_q.push_back(8'hB1 + 8'(k));
      step();
      bus.rx_valid = 1'b0;
      chk("rxfull_fill_head", bus.uart_r_data, rx_q[0]);
    end
    bus.uart_r_ctrl = 2'b01;
    bus.rx_valid    = 1'b1;
    bus.rx_byte     = 8'hB5;
    void'(rx_q.pop_front());
    rx_q.push_back(8'hB5);
    step();
    bus.rx_valid    = 1'b0;
    bus.uart_r_ctrl = '0;
    chk("rxfull_no_overrun", bus.rx_overrun, 0);
    chk("rxfull_head", bus.uart_r_data, rx_q[0]);
    step();
    n = 0;
    for (int i = 0; i < 8 && bus.uart_r_state === 1'b1; i++) begin
      ex = (rx_q.size() > 0) ? rx_q.pop_front() : 8'h00;
      chk("rxfull_drain", bus.uart_r_data, ex);
      bus.uart_r_ctrl = 2'b01;
      step();
      bus.uart_r_ctrl = '0;
      step();
      n++;
    end
    chk("rxfull_count", n, 4);
    chk("rxfull_empty_data", bus.uart_r_data, 0);

    // Reset abandons queued TX bytes
    busy_force = 1'b1;
    step();
    step();
    for (int k = 0; k < 4; k++) begin
      bus.uart_t_data = 8'h50 + 8'(k);
      bus.uart_t_ctrl = 1'b1;
      step();
      bus.uart_t_ctrl = 1'b0;
      step();
    end
    chk("rstmid_full", bus.uart_t_state, 0);
    rst_n = 1'b0;
    step();
    step();
    chk("rstmid_t_state", bus.uart_t_state, 1);
    rst_n = 1'b1;
    busy_force = 1'b0;
    s0 = n_starts;
    repeat (30) step();
    chk("rstmid_no_start", n_starts - s0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
